debug_dump_tx: RTL and testbench

- Debug-unit transmit sequencer between the MIPS datapath and the UART transmitter.
- On a dump command it reads 32-bit words from one source: the PC, the register bank (32 words) or data memory (2**NB_MEM_ADDR words).
- It splits each word into 4 bytes and hands them one at a time to the UART TX, waiting for each byte to complete.
- It is used after every step-by-step command and on explicit read commands from the host.

---
 rtl/debug_dump_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_debug_dump_tx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx
//  Description : Debug-unit transmit sequencer. On a dump request it reads
//                32-bit words from the PC, the register bank or data memory.
//                Each word is sent to the UART TX as four bytes, MSB first,
//                and every byte waits for the UART byte-complete tick.
//  Config      : DUMP_CHECKSUM_EN - when defined, an XOR checksum byte of
//                every byte sent is appended to the end of each frame.
//  Ports       : i_clock, i_reset (async, active-low)
//                i_start, i_sel      - dump request and source (0 PC, 1 REG,
//                                      2 MEM, 3 ignored)
//                i_pc                - PC value for sel 0
//                o_rd_addr, o_reg_rd_en, o_mem_rd_en, i_reg_data,
//                i_mem_data          - debug read port (data 1 cycle later)
//                o_tx_data, o_tx_start, i_tx_done_tick - UART TX handshake
//                o_busy, o_done      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_tx #(
    parameter int NB_DATA     = 8,
    parameter int NB_WORD     = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_MEM_ADDR = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [1:0]             i_sel,
    input  logic [NB_WORD-1:0]     i_pc,
    output logic [NB_MEM_ADDR-1:0] o_rd_addr,
    output logic                   o_reg_rd_en,
    output logic                   o_mem_rd_en,
    input  logic [NB_WORD-1:0]     i_reg_data,
    input  logic [NB_WORD-1:0]     i_mem_data,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done_tick,
    output logic                   o_busy,
    output logic                   o_done
);

    // One extra bit so the terminal count of the largest source never wraps.
    localparam int NB_CNT = ((NB_MEM_ADDR > NB_REG_ADDR) ? NB_MEM_ADDR : NB_REG_ADDR) + 1;

    localparam logic [NB_CNT-1:0]      C_LAST_REG = NB_CNT'((1 << NB_REG_ADDR) - 1);
    localparam logic [NB_CNT-1:0]      C_LAST_MEM = NB_CNT'((1 << NB_MEM_ADDR) - 1);
    localparam logic [NB_CNT-1:0]      C_CNT_ONE  = NB_CNT'(1);
    localparam logic [NB_MEM_ADDR-1:0] C_REG_MASK = NB_MEM_ADDR'((1 << NB_REG_ADDR) - 1);

    localparam logic [1:0] C_SEL_PC  = 2'd0;
    localparam logic [1:0] C_SEL_REG = 2'd1;
    localparam logic [1:0] C_SEL_RSV = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_REQ  = 4'd1,
        S_RD_WAIT = 4'd2,
        S_SEND    = 4'd3,
        S_WAIT_TX = 4'd4,
        S_NEXT    = 4'd5,
        S_FIN     = 4'd6
`ifdef DUMP_CHECKSUM_EN
        ,
        S_CKSUM   = 4'd7,
        S_CK_WAIT = 4'd8
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_sel;
    logic [NB_CNT-1:0]    r_word_cnt;
    logic [1:0]           r_byte_cnt;
    logic [NB_WORD-1:0]   r_shreg;
    logic [NB_DATA-1:0]   r_tx_hold;
    logic                 w_start_ok;
    logic                 w_last_word;
    logic [NB_WORD-1:0]   w_rd_word;
    logic [NB_DATA-1:0]   w_cur_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0]   r_cksum;
`endif

    assign w_start_ok = i_start && (i_sel != C_SEL_RSV);
    assign w_cur_byte = r_shreg[NB_WORD-1 -: NB_DATA];
    assign o_busy     = (r_state != S_IDLE);

    // Register addresses only use the low NB_REG_ADDR bits.
    assign o_rd_addr  = r_word_cnt[NB_MEM_ADDR-1:0]
                        & ((r_sel == C_SEL_REG) ? C_REG_MASK : {NB_MEM_ADDR{1'b1}});

    always_comb begin
        w_rd_word = i_mem_data;
        case (r_sel)
            C_SEL_PC:  w_rd_word = i_pc;
            C_SEL_REG: w_rd_word = i_reg_data;
            default:   w_rd_word = i_mem_data;
        endcase
    end

    always_comb begin
        w_last_word = (r_word_cnt == C_LAST_MEM);
        case (r_sel)
            C_SEL_PC:  w_last_word = (r_word_cnt == '0);
            C_SEL_REG: w_last_word = (r_word_cnt == C_LAST_REG);
            default:   w_last_word = (r_word_cnt == C_LAST_MEM);
        endcase
    end

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: latched source, counters, shift register and held TX byte
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sel      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_shreg    <= '0;
            r_tx_hold  <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_sel      <= i_sel;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_cksum    <= '0;
`endif
                    end
                end
                S_RD_WAIT: begin
                    r_shreg    <= w_rd_word;
                    r_byte_cnt <= '0;
                end
                S_SEND: begin
                    // Keep the byte visible on o_tx_data until the next SEND.
                    r_tx_hold <= w_cur_byte;
`ifdef DUMP_CHECKSUM_EN
                    r_cksum   <= r_cksum ^ w_cur_byte;
`endif
                end
                S_WAIT_TX: begin
                    if (i_tx_done_tick) begin
                        r_shreg    <= r_shreg << NB_DATA;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_NEXT: begin
                    if (!w_last_word) begin
                        r_word_cnt <= r_word_cnt + C_CNT_ONE;
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CKSUM: begin
                    r_tx_hold <= r_cksum;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next = r_state;
        o_tx_start   = 1'b0;
        o_tx_data    = r_tx_hold;
        o_reg_rd_en  = 1'b0;
        o_mem_rd_en  = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                o_reg_rd_en  = (r_sel == C_SEL_REG);
                o_mem_rd_en  = (r_sel == 2'd2);
                w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_state_next = S_SEND;
            end
            S_SEND: begin
                o_tx_data    = w_cur_byte;
                o_tx_start   = 1'b1;
                w_state_next = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done_tick) begin
                    w_state_next = (r_byte_cnt == 2'd3) ? S_NEXT : S_SEND;
                end
            end
            S_NEXT: begin
                if (!w_last_word) begin
                    w_state_next = S_RD_REQ;
                end else begin
`ifdef DUMP_CHECKSUM_EN
                    w_state_next = S_CKSUM;
`else
                    w_state_next = S_FIN;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CKSUM: begin
                o_tx_data    = r_cksum;
                o_tx_start   = 1'b1;
                w_state_next = S_CK_WAIT;
            end
            S_CK_WAIT: begin
                if (i_tx_done_tick) begin
                    w_state_next = S_FIN;
                end
            end
`endif
            S_FIN: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_dump_tx
//  Description : Self-checking bench for debug_dump_tx. Register bank, data
//                memory and UART TX are modelled behaviourally; expected
//                frames are built directly from the source words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_dump_tx;

    localparam int NB_DATA     = 8;
    localparam int NB_WORD     = 32;
    localparam int NB_REG_ADDR = 5;
    localparam int NB_MEM_ADDR = 5;
    localparam int MEM_WORDS   = 1 << NB_MEM_ADDR;

    typedef logic [7:0]             byte_q_t[$];
    typedef logic [NB_MEM_ADDR-1:0] addr_q_t[$];

    logic                   i_clock = 1'b0;
    logic                   i_reset = 1'b0;
    logic                   i_start = 1'b0;
    logic [1:0]             i_sel   = 2'd0;
    logic [NB_WORD-1:0]     i_pc    = '0;
    logic [NB_MEM_ADDR-1:0] o_rd_addr;
    logic                   o_reg_rd_en;
    logic                   o_mem_rd_en;
    logic [NB_WORD-1:0]     i_reg_data = '0;
    logic [NB_WORD-1:0]     i_mem_data = '0;
    logic [NB_DATA-1:0]     o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done_tick;
    logic                   o_busy;
    logic                   o_done;

    logic model_tick = 1'b0;
    logic spur_tick  = 1'b0;
    assign i_tx_done_tick = model_tick | spur_tick;

    debug_dump_tx #(
        .NB_DATA(NB_DATA), .NB_WORD(NB_WORD),
        .NB_REG_ADDR(NB_REG_ADDR), .NB_MEM_ADDR(NB_MEM_ADDR)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_sel(i_sel),
        .i_pc(i_pc), .o_rd_addr(o_rd_addr), .o_reg_rd_en(o_reg_rd_en),
        .o_mem_rd_en(o_mem_rd_en), .i_reg_data(i_reg_data), .i_mem_data(i_mem_data),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_tx_done_tick(i_tx_done_tick), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    // Source memories and UART model
    logic [31:0] reg_arr[32];
    logic [31:0] mem_arr[MEM_WORDS];
    int          tx_dly = 1;
    int          tx_cnt = 0;

    always @(posedge i_clock) begin
        if (o_reg_rd_en) i_reg_data <= reg_arr[o_rd_addr];
        if (o_mem_rd_en) i_mem_data <= mem_arr[o_rd_addr];
    end

    always @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            model_tick <= 1'b0;
            tx_cnt     <= 0;
        end else begin
            model_tick <= 1'b0;
            if (o_tx_start)       tx_cnt <= tx_dly;
            else if (tx_cnt == 1) begin model_tick <= 1'b1; tx_cnt <= 0; end
            else if (tx_cnt > 1)  tx_cnt <= tx_cnt - 1;
        end
    end

    // Monitor: only ever appends, tests work from recorded base indices
    int      cyc = 0;
    int      done_cnt = 0;
    byte_q_t rx_q;
    int      tx_cyc_q[$];
    addr_q_t reg_addr_q;
    addr_q_t mem_addr_q;

    always @(posedge i_clock) begin
        cyc <= cyc + 1;
        if (o_tx_start) begin
            rx_q.push_back(o_tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (o_reg_rd_en) reg_addr_q.push_back(o_rd_addr);
        if (o_mem_rd_en) mem_addr_q.push_back(o_rd_addr);
        if (o_done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int rx_base, reg_base, mem_base, done_base, start_cyc;

    // Reference frame: words of the source, MSB byte first, optional XOR byte
    function automatic byte_q_t exp_frame(input logic [1:0] sel);
        byte_q_t     q;
        logic [7:0]  cs = 8'h00;
        logic [31:0] w;
        int          n = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 32 : MEM_WORDS;
        for (int k = 0; k < n; k++) begin
            w = (sel == 2'd0) ? i_pc : (sel == 2'd1) ? reg_arr[k] : mem_arr[k];
            for (int b = 3; b >= 0; b--) begin
                q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        q.push_back(cs);
`endif
        return q;
    endfunction

    function automatic int first_diff(input byte_q_t a, input byte_q_t b);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic int addr_seq_diff(input addr_q_t q, input int base, input int n);
        if (q.size() - base != n) return -2;
        for (int i = 0; i < n; i++) if (int'(q[base + i]) != i) return i;
        return -1;
    endfunction

    task automatic mark_bases();
        rx_base   = rx_q.size();
        reg_base  = reg_addr_q.size();
        mem_base  = mem_addr_q.size();
        done_base = done_cnt;
    endtask

    // Issue one dump and wait for o_done; noise re-requests while busy.
    task automatic run_dump(input logic [1:0] sel, input bit noise, output bit timeout);
        @(negedge i_clock);
        mark_bases();
        i_sel     = sel;
        i_start   = 1'b1;
        start_cyc = cyc;
        @(negedge i_clock);
        i_start = 1'b0;
        timeout = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            if (done_cnt != done_base) begin timeout = 1'b0; break; end
            if (noise && $urandom_range(3) == 0) begin
                i_start = 1'b1;
                i_sel   = 2'($urandom_range(3));
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clock);
        end
        i_start = 1'b0;
        repeat (4) @(negedge i_clock);
    endtask

    task automatic check_frame(input string name, input logic [1:0] sel, input byte_q_t exp);
        byte_q_t got = rx_q[rx_base:$];
        int d = first_diff(got, exp);
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL %s frame sel%0d: byte %0d got %02h expected %02h (got %0d bytes, expected %0d)",
                     name, sel, d, got[d], exp[d], got.size(), exp.size());
        end
        checks++;
        if (done_cnt - done_base !== 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected 1", name, done_cnt - done_base);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clock);
        checks++;
        if ({o_busy, o_done, o_tx_start, o_reg_rd_en, o_mem_rd_en, o_tx_data, o_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b start=%b ren=%b men=%b data=%02h addr=%0d expected all 0",
                     o_busy, o_done, o_tx_start, o_reg_rd_en, o_mem_rd_en, o_tx_data, o_rd_addr);
        end
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
    endtask

    task automatic test_reset_mid_dump();
        bit      to;
        bit      reached = 1'b0;
        byte_q_t exp;
        for (int k = 0; k < 32; k++) reg_arr[k] = $urandom;
        tx_dly = $urandom_range(6, 2);
        @(negedge i_clock);
        mark_bases();
        i_sel = 2'd1; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (rx_q.size() >= rx_base + 2) begin reached = 1'b1; break; end
            @(negedge i_clock);
        end
        checks++;
        if (reached !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: got %0d bytes expected 2 within bound", rx_q.size() - rx_base);
        end
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_tx_start, o_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy/start/done got %b expected 000", {o_busy, o_tx_start, o_done});
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (10) @(negedge i_clock);
        checks++;
        if (done_cnt - done_base !== 0 || rx_q.size() - rx_base !== 2) begin
            errors++;
            $display("FAIL reset_mid_after: done %0d bytes %0d expected 0 and 2",
                     done_cnt - done_base, rx_q.size() - rx_base);
        end
        i_pc = $urandom;
        exp  = exp_frame(2'd0);
        run_dump(2'd0, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL reset_fresh_timeout: got 1 expected 0"); end
        check_frame("reset_fresh", 2'd0, exp);
    endtask

    task automatic test_pc();
        bit      to;
        byte_q_t exp;
        int      lat;
        i_pc   = 32'h0000_0024;
        tx_dly = 10;
        exp    = exp_frame(2'd0);
        run_dump(2'd0, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL pc_timeout: got 1 expected 0"); end
        check_frame("pc", 2'd0, exp);
        lat = (tx_cyc_q.size() > rx_base) ? tx_cyc_q[rx_base] - start_cyc : -1;
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL pc_latency: got %0d expected 3", lat); end
        checks++;
        if (reg_addr_q.size() - reg_base + mem_addr_q.size() - mem_base !== 0) begin
            errors++;
            $display("FAIL pc_rd_en: got %0d enables expected 0",
                     reg_addr_q.size() - reg_base + mem_addr_q.size() - mem_base);
        end
    endtask

    task automatic test_reg_bank();
        bit      to;
        byte_q_t exp, got;
        int      d;
        for (int k = 0; k < 32; k++) reg_arr[k] = 32'h1100_0000 + k;
        tx_dly = $urandom_range(4, 1);
        exp    = exp_frame(2'd1);
        run_dump(2'd1, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL reg_timeout: got 1 expected 0"); end
        check_frame("reg", 2'd1, exp);
        got = rx_q[rx_base:$];
        checks++;
        if ({got[124], got[125], got[126], got[127]} !== 32'h1100_001F) begin
            errors++;
            $display("FAIL reg_word31: got %02h%02h%02h%02h expected 1100001f", got[124], got[125], got[126], got[127]);
        end
        d = addr_seq_diff(reg_addr_q, reg_base, 32);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL reg_addr_seq: diff code %0d expected -1", d); end
        checks++;
        if (mem_addr_q.size() - mem_base !== 0) begin
            errors++;
            $display("FAIL reg_mem_en: got %0d enables expected 0", mem_addr_q.size() - mem_base);
        end
    endtask

    task automatic test_mem();
        bit      to;
        byte_q_t exp, got;
        int      d;
        for (int k = 0; k < MEM_WORDS; k++) mem_arr[k] = 32'hDEAD_0000 | k;
        tx_dly = $urandom_range(3, 1);
        exp    = exp_frame(2'd2);
        run_dump(2'd2, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL mem_timeout: got 1 expected 0"); end
        check_frame("mem", 2'd2, exp);
        got = rx_q[rx_base:$];
        checks++;
        if ({got[124], got[125], got[126], got[127]} !== 32'hDEAD_001F) begin
            errors++;
            $display("FAIL mem_last_word: got %02h%02h%02h%02h expected dead001f", got[124], got[125], got[126], got[127]);
        end
        d = addr_seq_diff(mem_addr_q, mem_base, MEM_WORDS);
        checks++;
        if (d !== -1) begin errors++; $display("FAIL mem_addr_seq: diff code %0d expected -1", d); end
        checks++;
        if (reg_addr_q.size() - reg_base !== 0) begin
            errors++;
            $display("FAIL mem_reg_en: got %0d enables expected 0", reg_addr_q.size() - reg_base);
        end
    endtask

    task automatic test_ignored();
        bit      to;
        bit      finished = 1'b0;
        byte_q_t exp;
        // Reserved source in IDLE
        @(negedge i_clock);
        mark_bases();
        i_sel = 2'd3; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        repeat (20) @(negedge i_clock);
        checks++;
        if ({o_busy, 8'(rx_q.size() - rx_base), 8'(done_cnt - done_base)} !== 17'd0) begin
            errors++;
            $display("FAIL sel3_ignored: busy %b bytes %0d done %0d expected 0 0 0",
                     o_busy, rx_q.size() - rx_base, done_cnt - done_base);
        end
        // Requests while busy must not disturb the running dump
        for (int k = 0; k < MEM_WORDS; k++) mem_arr[k] = $urandom;
        tx_dly = $urandom_range(2, 1);
        exp    = exp_frame(2'd2);
        run_dump(2'd2, 1'b1, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout: got 1 expected 0"); end
        check_frame("busy_start", 2'd2, exp);
        // Spurious done tick during RD_WAIT
        i_pc   = $urandom;
        tx_dly = 3;
        exp    = exp_frame(2'd0);
        @(negedge i_clock);
        mark_bases();
        i_sel = 2'd0; i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        @(negedge i_clock);
        spur_tick = 1'b1;
        @(negedge i_clock);
        spur_tick = 1'b0;
        checks++;
        if (o_tx_start !== 1'b1) begin errors++; $display("FAIL spur_send_timing: o_tx_start got %b expected 1", o_tx_start); end
        for (int n = 0; n < 200; n++) begin
            if (done_cnt != done_base) begin finished = 1'b1; break; end
            @(negedge i_clock);
        end
        repeat (4) @(negedge i_clock);
        checks++;
        if (finished !== 1'b1) begin errors++; $display("FAIL spur_timeout: got 0 expected 1"); end
        check_frame("spur_tick", 2'd0, exp);
    endtask

    task automatic test_checksum();
        bit      to;
        byte_q_t exp, got;
        i_pc   = 32'h1234_5678;
        tx_dly = $urandom_range(5, 1);
        exp    = exp_frame(2'd0);
        run_dump(2'd0, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL cksum_timeout: got 1 expected 0"); end
        check_frame("cksum", 2'd0, exp);
        got = rx_q[rx_base:$];
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if ({got[0], got[1], got[2], got[3], got[4]} !== 40'h12_34_56_78_08) begin
            errors++;
            $display("FAIL cksum_bytes: got %02h %02h %02h %02h %02h expected 12 34 56 78 08",
                     got[0], got[1], got[2], got[3], got[4]);
        end
`else
        checks++;
        if (got.size() !== 4) begin errors++; $display("FAIL nocksum_len: got %0d expected 4", got.size()); end
`endif
    endtask

    task automatic test_random();
        bit         to;
        byte_q_t    exp;
        logic [1:0] sel;
        for (int it = 0; it < 6; it++) begin
            sel    = 2'($urandom_range(2));
            i_pc   = $urandom;
            for (int k = 0; k < 32; k++) reg_arr[k] = $urandom;
            for (int k = 0; k < MEM_WORDS; k++) mem_arr[k] = $urandom;
            tx_dly = $urandom_range(5, 1);
            exp    = exp_frame(sel);
            run_dump(sel, 1'b1, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL random_timeout: iter %0d got 1 expected 0", it); end
            check_frame("random", sel, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) reg_arr[k] = '0;
        for (int k = 0; k < MEM_WORDS; k++) mem_arr[k] = '0;
        test_reset();
        test_reset_mid_dump();
        test_pc();
        test_reg_bank();
        test_mem();
        test_ignored();
        test_checksum();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
